boolean_sweep_ctrl: RTL

BOOLEAN_SWEEP_CTRL -- requirements
Module: boolean_sweep_ctrl

---
 rtl/boolean_sweep_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/boolean_sweep_ctrl.sv
// boolean_sweep_ctrl
//   Walks a 3-input boolean datapath through all eight input vectors {a,b,c} = 0..7.
//   Each vector is held for SETTLE_CYCLES cycles, then y is captured into truth_table[idx].
//   A one-cycle done pulse marks the end of a complete sweep. An abort returns to idle
//   without a done pulse and keeps any bits captured so far.
//
//   Optional feature: define BOOLEAN_SWEEP_CHECK_EN to add a compare against expected_tt.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request a sweep (honoured only when idle)
//   abort         cancel a sweep in progress
//   y             datapath output under test
//   a, b, c       registered datapath inputs (a = MSB of the vector index)
//   busy          sweep in progress (drive or sample phase)
//   done          one-cycle pulse when a sweep completes
//   truth_table   captured y values, bit i = y for index i
//   expected_tt   (BOOLEAN_SWEEP_CHECK_EN) reference truth table
//   mismatch      (BOOLEAN_SWEEP_CHECK_EN) any bit of mismatch_mask set
//   mismatch_mask (BOOLEAN_SWEEP_CHECK_EN) truth_table XOR expected_tt, taken at done
module boolean_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
`ifdef BOOLEAN_SWEEP_CHECK_EN
  input  logic [7:0] expected_tt,
  output logic       mismatch,
  output logic [7:0] mismatch_mask,
`endif
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table
);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSample,
    StDone
  } state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] tt_q, tt_d;
  logic       accept;

  // abort has priority over start, so a combined request never starts a sweep.
  assign accept = (state_q == StIdle) && start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      abc_q   <= 3'd0;
      tt_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      tt_q    <= tt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    abc_d   = abc_q;
    tt_d    = tt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StDrive;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          abc_d   = 3'd0;
          tt_d    = 8'h00;
        end
      end
      StDrive: begin
        if (abort) begin
          state_d = StIdle;
          abc_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CntLast) begin
            state_d = StSample;
          end
        end
      end
      StSample: begin
        // An abort on the capture edge drops this vector's result.
        if (abort) begin
          state_d = StIdle;
          abc_d   = 3'd0;
        end else begin
          tt_d[idx_q] = y;
          if (idx_q == 3'd7) begin
            state_d = StDone;
          end else begin
            state_d = StDrive;
            idx_d   = idx_q + 3'd1;
            abc_d   = idx_q + 3'd1;
            cnt_d   = 4'd0;
          end
        end
      end
      StDone: begin
        // idx stays at 7; only the driven vector returns to zero.
        state_d = StIdle;
        abc_d   = 3'd0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign {a, b, c}   = abc_q;
  assign busy        = (state_q == StDrive) || (state_q == StSample);
  assign done        = (state_q == StDone);
  assign truth_table = tt_q;

`ifdef BOOLEAN_SWEEP_CHECK_EN
  logic       mismatch_q;
  logic [7:0] mismatch_mask_q;

  // Both results are computed from the final truth table in the done cycle, so
  // mismatch reflects the same sweep as mismatch_mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q      <= 1'b0;
      mismatch_mask_q <= 8'h00;
    end else if (accept) begin
      mismatch_q      <= 1'b0;
      mismatch_mask_q <= 8'h00;
    end else if (state_q == StDone) begin
      mismatch_mask_q <= tt_q ^ expected_tt;
      mismatch_q      <= |(tt_q ^ expected_tt);
    end
  end

  assign mismatch      = mismatch_q;
  assign mismatch_mask = mismatch_mask_q;
`endif

endmodule
